// File: rtl/mio_pkg.sv
// Shared address map, FSM state and access-kind encodings for the memory/IO responder.
package mio_pkg;

    localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
    localparam logic [31:0] TIMER_ADDR = 32'hF000_0004;

    typedef enum logic [1:0] {IDLE, RAM_WAIT_ST, RESP} state_t;

    typedef enum logic [1:0] {KIND_RAM, KIND_GPIO, KIND_TIMER, KIND_UNMAP} kind_t;

    // First byte address past the RAM window.
    function automatic logic [32:0] ram_limit(input int aw);
        return 33'd1 << (aw + 2);
    endfunction

    function automatic kind_t decode_addr(input logic [31:0] addr, input int aw);
        if ({1'b0, addr} < ram_limit(aw)) return KIND_RAM;
        if (addr[31:2] == GPIO_ADDR[31:2]) return KIND_GPIO;
        if (addr[31:2] == TIMER_ADDR[31:2]) return KIND_TIMER;
        return KIND_UNMAP;
    endfunction

endpackage

// File: rtl/mio_timer.sv
// 32-bit down-counter that holds at zero and flags expiry on cnt_irq.
module mio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] count,
    output logic        irq
);

    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;
    logic        armed_q, armed_d;

    // armed keeps the post-reset zero count from raising irq before any load.
    always_comb begin
        count_d = count_q;
        irq_d   = irq_q;
        armed_d = armed_q;
        if (load) begin
            count_d = load_val;
            irq_d   = 1'b0;
            armed_d = 1'b1;
        end else begin
            if (count_q != 32'd0) count_d = count_q - 32'd1;
            if (armed_q && (count_q <= 32'd1)) begin
                irq_d   = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 32'd0;
            irq_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            irq_q   <= irq_d;
            armed_q <= armed_d;
        end
    end

    assign count = count_q;
    assign irq   = irq_q;

endmodule

// File: rtl/mio_responder.sv
// Word-wide load/store responder: decodes core requests onto data RAM, GPIO and the timer.
//
// state       | meaning
// IDLE        | waiting for mem_w/mem_req; request captured on accept
// RAM_WAIT_ST | RAM read issued, counting RAM_WAIT cycles before sampling ram_rdata
// RESP        | mio_ready high for one cycle; register writes land on the closing edge
module mio_responder
    import mio_pkg::*;
#(
    parameter int RAM_AW   = 12,
    parameter int RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    input  logic              mem_w,
    input  logic              mem_req,
    output logic [31:0]       rdata_out,
    output logic              mio_ready,
    output logic              cpu_mio,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              cnt_irq
);

    localparam logic [2:0] WAIT_INIT = (RAM_WAIT > 0) ? 3'(RAM_WAIT - 1) : 3'd0;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic              write_q, write_d;
    logic [2:0]        wait_q, wait_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mio_ready_q, mio_ready_d;
    logic              cpu_mio_q, cpu_mio_d;
    logic              ram_we_q, ram_we_d;
    logic              bus_err_q, bus_err_d;
    logic [15:0]       led_q, led_d;

    kind_t       kind_in, resp_kind;
    logic        resp_go, resp_wr, tmr_load;
    logic [31:0] tmr_count;

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        write_d     = write_q;
        wait_d      = wait_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        mio_ready_d = 1'b0;
        cpu_mio_d   = 1'b0;
        ram_we_d    = 1'b0;
        bus_err_d   = bus_err_q;
        led_d       = led_q;
        tmr_load    = 1'b0;
        kind_in     = decode_addr(addr_in, RAM_AW);
        resp_go     = 1'b0;
        resp_kind   = kind_q;
        resp_wr     = write_q;

        case (state_q)
            IDLE: begin
                if (mem_w || mem_req) begin
                    kind_d      = kind_in;
                    write_d     = mem_w;
                    ram_addr_d  = addr_in[RAM_AW+1:2];
                    ram_wdata_d = wdata_in;
                    if (!mem_w && kind_in == KIND_RAM && RAM_WAIT > 0) begin
                        state_d = RAM_WAIT_ST;
                        wait_d  = WAIT_INIT;
                    end else begin
                        resp_go   = 1'b1;
                        resp_kind = kind_in;
                        resp_wr   = mem_w;
                    end
                end
            end
            RAM_WAIT_ST: begin
                if (wait_q == 3'd0) resp_go = 1'b1;
                else                wait_d  = wait_q - 3'd1;
            end
            RESP: begin
                state_d = IDLE;
                if (write_q && kind_q == KIND_GPIO) led_d = ram_wdata_q[15:0];
                tmr_load = write_q && (kind_q == KIND_TIMER);
            end
            default: state_d = IDLE;
        endcase

        // Everything the core sees in RESP is registered on the edge entering it.
        if (resp_go) begin
            state_d     = RESP;
            mio_ready_d = 1'b1;
            cpu_mio_d   = (resp_kind == KIND_GPIO) || (resp_kind == KIND_TIMER);
            ram_we_d    = resp_wr && (resp_kind == KIND_RAM);
            if (resp_kind == KIND_UNMAP) bus_err_d = 1'b1;
            if (!resp_wr) begin
                case (resp_kind)
                    KIND_RAM:   rdata_d = ram_rdata;
                    KIND_GPIO:  rdata_d = {sw_in, led_q};
                    KIND_TIMER: rdata_d = tmr_count;
                    default:    rdata_d = 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            kind_q      <= KIND_RAM;
            write_q     <= 1'b0;
            wait_q      <= 3'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            mio_ready_q <= 1'b0;
            cpu_mio_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            led_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            write_q     <= write_d;
            wait_q      <= wait_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
            mio_ready_q <= mio_ready_d;
            cpu_mio_q   <= cpu_mio_d;
            ram_we_q    <= ram_we_d;
            bus_err_q   <= bus_err_d;
            led_q       <= led_d;
        end
    end

    mio_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (ram_wdata_q),
        .count    (tmr_count),
        .irq      (cnt_irq)
    );

    assign rdata_out = rdata_q;
    assign mio_ready = mio_ready_q;
    assign cpu_mio   = cpu_mio_q;
    assign bus_err   = bus_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign led_out   = led_q;

endmodule
